// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch front end.
// Included first so the interface, FIFO and top all see one definition of a fetch entry.
package instruction_prefetch_unit_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_prefetch_unit_if.sv
// Fetch-side bus bundle: imem request/response, execute redirect and decode handshake.
// The master modport is the prefetch unit; the slave modport is memory/execute/decode.
interface instruction_prefetch_unit_if;
  import instruction_prefetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [ILEN-1:0] inst_data;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    output inst_ready
  );

endinterface

// File: rtl/instruction_prefetch_unit_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, inst} with clear; push and pop may
// coincide at any occupancy, including full.
module instruction_prefetch_unit_fetch_fifo
  import instruction_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Decoupled fetch front end: credit-limited in-order imem requests, a small
// {pc, inst} queue to decode, and redirect flush that discards stale responses.
module instruction_prefetch_unit
  import instruction_prefetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  instruction_prefetch_unit_if.master  bus
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP  = XLEN'(INST_BYTES);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  fetch_entry_t    fifo_head, push_entry;
  logic            req_valid, req_fire, rsp_drop, push, pop, flush;

  // Credit covers queued plus in-flight entries so a response never finds the queue full.
  assign occupancy  = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign req_valid  = !rst && !bus.redirect_valid && (occupancy < DEPTH_C);
  assign req_fire   = req_valid && bus.imem_req_ready;
  assign flush      = bus.redirect_valid;
  assign pop        = bus.inst_valid && bus.inst_ready && !flush;
  assign push       = bus.imem_rsp_valid && !rsp_drop && !flush;
  assign push_entry = '{pc: resp_pc_q, inst: bus.imem_rsp_data};

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = (fifo_count != '0);
  assign bus.inst_pc        = bus.inst_valid ? fifo_head.pc   : '0;
  assign bus.inst_data      = bus.inst_valid ? fifo_head.inst : '0;

  instruction_prefetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    if (flush) begin
      fetch_pc_d = align_word(bus.redirect_pc);
      resp_pc_d  = align_word(bus.redirect_pc);
      // outstanding already includes any earlier pending drops, so it alone is the new stale count.
      drop_cnt_d = outstanding_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (push)     resp_pc_d  = resp_pc_q + STEP;
      if (bus.imem_rsp_valid && rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
  end

  always_comb begin
    rsp_drop = (state_q == ST_DRAIN);
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Randomized scoreboard bench for instruction_prefetch_unit with a variable-latency
// memory model and an epoch-tagged reference of which fetches reach decode.
module tb_instruction_prefetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; int avail; } exp_t;

  logic clk;
  logic rst;
  instruction_prefetch_unit_if bus();

  instruction_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   epoch = 0;
  int   last_due = 0;
  int   fire_cnt = 0;
  int   lat_lo = 1, lat_hi = 1;
  int   rdy_pct = 100, inst_pct = 100, redir_pct = 0;
  logic [31:0] model_pc = RESET_PC;
  req_t pipe[$];
  exp_t exp_q[$];

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // One clock of stimulus: random handshakes, optional redirect, in-order memory response.
  task automatic step(input bit redir, input logic [31:0] rpc);
    req_t r;
    @(posedge clk); #1;
    rst                = 1'b0;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.inst_ready     = ($urandom_range(99) < inst_pct);
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir ? rpc : $urandom;
    if (redir) begin
      epoch++;
      exp_q.delete();
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      r = pipe.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(r.addr);
      if (!redir && r.epoch == epoch)
        exp_q.push_back('{pc: r.addr, data: mem_word(r.addr), avail: cyc + 1});
    end
  endtask

  task automatic rand_step();
    bit redir;
    redir = ($urandom_range(99) < redir_pct);
    step(redir, $urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    pipe.delete();
    exp_q.delete();
    epoch++;
    last_due = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid",  bus.imem_req_valid, 0);
    chk("rst_req_addr",   bus.imem_req_addr,  RESET_PC);
    chk("rst_inst_valid", bus.inst_valid,     0);
    chk("rst_inst_pc",    bus.inst_pc,        0);
    chk("rst_inst_data",  bus.inst_data,      0);
  endtask

  task automatic wait_inst(input string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        step(0, 0);
        @(negedge clk);
        found = bus.inst_valid;
      end
    end
    chk(nm, found, 1);
  endtask

  // Monitor: compares request channel and decode channel against the reference every cycle.
  always @(negedge clk) begin
    int   cnt;
    int   outst;
    int   lat;
    int   due;
    bit   exp_rv;
    if (rst) begin
      model_pc = RESET_PC;
    end else begin
      cnt = 0;
      foreach (exp_q[i]) if (exp_q[i].avail <= cyc) cnt++;
      outst  = pipe.size() + (bus.imem_rsp_valid ? 1 : 0);
      exp_rv = !bus.redirect_valid && (cnt + outst < DEPTH);
      chk("req_valid", bus.imem_req_valid, exp_rv);
      if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, model_pc);
      if (bus.redirect_valid) begin
        model_pc = {bus.redirect_pc[31:2], 2'b00};
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        lat = $urandom_range(lat_hi, lat_lo);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pipe.push_back('{addr: bus.imem_req_addr, epoch: epoch, due: due});
        model_pc = model_pc + 32'd4;
        fire_cnt++;
      end
      if (!bus.redirect_valid) begin
        chk("inst_valid", bus.inst_valid, (cnt != 0));
        if (bus.inst_valid && cnt != 0) begin
          chk("inst_pc",   bus.inst_pc,   exp_q[0].pc);
          chk("inst_data", bus.inst_data, exp_q[0].data);
          if (bus.inst_ready) void'(exp_q.pop_front());
        end else if (!bus.inst_valid) begin
          chk("idle_pc",   bus.inst_pc,   0);
          chk("idle_data", bus.inst_data, 0);
        end
      end
    end
  end

  initial begin
    rst                = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;

    // Streaming with single-cycle memory.
    do_reset();
    lat_lo = 1; lat_hi = 1; rdy_pct = 100; inst_pct = 100;
    step(0, 0); @(negedge clk);
    chk("first_req_valid", bus.imem_req_valid, 1);
    chk("first_req_addr",  bus.imem_req_addr,  RESET_PC);
    step(0, 0); @(negedge clk);
    chk("first_inst_not_yet", bus.inst_valid, 0);
    step(0, 0); @(negedge clk);
    chk("first_inst_valid", bus.inst_valid, 1);
    chk("first_inst_pc",    bus.inst_pc,    32'h0);
    for (int i = 0; i < 20; i++) step(0, 0);

    // Decode stalled: exactly DEPTH requests, then resume.
    do_reset();
    inst_pct = 0; fire_cnt = 0;
    for (int i = 0; i < 15; i++) step(0, 0);
    @(negedge clk);
    chk("stall_fire_cnt",   fire_cnt,           DEPTH);
    chk("stall_req_valid",  bus.imem_req_valid, 0);
    chk("stall_inst_valid", bus.inst_valid,     1);
    chk("stall_inst_pc",    bus.inst_pc,        32'h0);
    inst_pct = 100; fire_cnt = 0;
    for (int i = 0; i < 10; i++) step(0, 0);
    chk("resume_fires", (fire_cnt >= 8), 1);

    // Three-cycle memory, redirect to 0x103 with two requests outstanding.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    step(0, 0);
    step(0, 0);
    step(1, 32'h0000_0103);
    step(0, 0); @(negedge clk);
    chk("redir_req_valid", bus.imem_req_valid, 1);
    chk("redir_req_addr",  bus.imem_req_addr,  32'h0000_0100);
    wait_inst("redir_wait_inst");
    chk("redir_first_pc", bus.inst_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a decode pop.
    do_reset();
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 8; i++) step(0, 0);
    step(1, 32'h0000_0200);
    step(0, 0); @(negedge clk);
    chk("same_cycle_flush", bus.inst_valid, 0);
    wait_inst("same_cycle_wait");
    chk("same_cycle_pc", bus.inst_pc, 32'h0000_0200);

    // Address wrap at the top of memory.
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 4; i++) step(0, 0);
    step(1, 32'hFFFF_FFF8);
    wait_inst("wrap_wait");
    chk("wrap_pc0", bus.inst_pc, 32'hFFFF_FFF8);
    step(0, 0); @(negedge clk);
    chk("wrap_pc1", bus.inst_pc, 32'hFFFF_FFFC);
    step(0, 0); @(negedge clk);
    chk("wrap_pc2", bus.inst_pc, 32'h0000_0000);

    // Random traffic: variable latency, backpressure, redirects.
    lat_lo = 1; lat_hi = 4; rdy_pct = 70; inst_pct = 70; redir_pct = 4;
    for (int i = 0; i < 2500; i++) rand_step();
    redir_pct = 0;

    // Reset with queued entries and requests in flight.
    lat_lo = 3; lat_hi = 3; rdy_pct = 100; inst_pct = 0;
    for (int i = 0; i < 5; i++) step(0, 0);
    do_reset();
    inst_pct = 100;
    step(0, 0); @(negedge clk);
    chk("post_rst_req_valid", bus.imem_req_valid, 1);
    chk("post_rst_req_addr",  bus.imem_req_addr,  RESET_PC);
    for (int i = 0; i < 20; i++) step(0, 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
